// File: rtl/gol_stepper.sv
// Game of Life engine for an 8x8 board: accepts a board and a generation count,
// evolves it one row per clock and hands back the final board over valid/ready.
`timescale 1ns/1ps
module gol_stepper #(
    parameter int unsigned WRAP  = 0,
    parameter int unsigned GEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      grid_in,
    input  logic [GEN_W-1:0] num_gens,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      grid_out,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [63:0]      cur_q;
    logic [63:0]      nxt_q;
    logic [2:0]       row_q;
    logic [GEN_W-1:0] gen_q;
    logic [GEN_W-1:0] target_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [7:0]       row_bits_d;
    logic [3:0]       n_cnt;
    logic             self_alive;
    logic [GEN_W-1:0] gen_inc;

    assign gen_inc = gen_q + GEN_W'(1);

    // Cell lookup; negative or >7 coordinates wrap via 3-bit truncation when WRAP is set.
    function automatic logic cell_at(input logic [63:0] b, input int r, input int c);
        logic       res;
        logic [5:0] idx;
        idx = {3'(r), 3'(c)};
        if (WRAP != 0) begin
            res = b[idx];
        end else if (r < 0 || r > 7 || c < 0 || c > 7) begin
            res = 1'b0;
        end else begin
            res = b[idx];
        end
        return res;
    endfunction

    always_comb begin
        row_bits_d = '0;
        n_cnt      = '0;
        self_alive = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_cnt = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr != 0 || dc != 0) begin
                        n_cnt = n_cnt + 4'(cell_at(cur_q, int'(row_q) + dr, c + dc));
                    end
                end
            end
            self_alive    = cell_at(cur_q, int'(row_q), c);
            row_bits_d[c] = (n_cnt == 4'd3) || (self_alive && n_cnt == 4'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            nxt_q       <= '0;
            row_q       <= '0;
            gen_q       <= '0;
            target_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        cur_q      <= grid_in;
                        target_q   <= num_gens;
                        gen_q      <= '0;
                        row_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (num_gens == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    nxt_q[{row_q, 3'b000} +: 8] <= row_bits_d;
                    if (row_q == 3'd7) begin
                        // Commit the whole generation at once so every row saw the same cur.
                        cur_q <= {row_bits_d, nxt_q[55:0]};
                        row_q <= '0;
                        gen_q <= gen_inc;
                        if (gen_inc == target_q) begin
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        row_q <= row_q + 3'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign grid_out  = cur_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_gol_stepper.sv
// Bench for gol_stepper: bounded and toroidal instances share stimulus; a scoreboard
// of model-predicted boards is checked when out_valid rises.
`timescale 1ns/1ps
module tb_gol_stepper;

    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] grid_in = '0;
    logic [7:0]  num_gens = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, busy0;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] grid_out0, grid_out1;
    logic [7:0]  gen_count0, gen_count1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] exp0;
        logic [63:0] exp1;
        logic [7:0]  gen;
        int          lat;
        time         t0;
    } job_t;

    job_t sb[$];
    logic ov_prev = 1'b0;

    always #HALF clk = ~clk;

    gol_stepper #(.WRAP(0), .GEN_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .grid_in(grid_in), .num_gens(num_gens), .out_valid(out_valid0),
        .out_ready(out_ready), .grid_out(grid_out0), .gen_count(gen_count0), .busy(busy0)
    );

    gol_stepper #(.WRAP(1), .GEN_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .grid_in(grid_in), .num_gens(num_gens), .out_valid(out_valid1),
        .out_ready(out_ready), .grid_out(grid_out1), .gen_count(gen_count1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] life_step(input logic [63:0] b, input bit wrap);
        logic [63:0] nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                            continue;
                        end
                        n += int'(b[rr * 8 + cc]);
                    end
                end
                nb[r * 8 + c] = b[r * 8 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nb;
    endfunction

    function automatic logic [63:0] life_n(input logic [63:0] b, input int n, input bit wrap);
        logic [63:0] x;
        x = b;
        for (int i = 0; i < n; i++) x = life_step(x, wrap);
        return x;
    endfunction

    // First cycle out_valid is seen: pop the oldest job and compare both instances.
    always @(negedge clk) begin
        if (reset_n && out_valid0 && !ov_prev) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid0), 64'd0);
            end else begin
                job_t e;
                e = sb.pop_front();
                check("ov_wrap1_sync", 64'(out_valid1), 64'd1);
                check("grid_wrap0", grid_out0, e.exp0);
                check("grid_wrap1", grid_out1, e.exp1);
                check("gen_count", 64'(gen_count0), 64'(e.gen));
                check("latency", 64'(($time - e.t0 - HALF) / PERIOD), 64'(e.lat));
            end
        end
        ov_prev <= out_valid0;
    end

    task automatic submit(input logic [63:0] g, input logic [7:0] n);
        job_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!in_ready0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready0) begin
            check("in_ready_wait", 64'(in_ready0), 64'd1);
            return;
        end
        in_valid = 1'b1;
        grid_in  = g;
        num_gens = n;
        @(posedge clk);
        e.exp0 = life_n(g, int'(n), 1'b0);
        e.exp1 = life_n(g, int'(n), 1'b1);
        e.gen  = n;
        e.lat  = 8 * int'(n);
        e.t0   = $time;
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [63:0] hold_exp;
    int          k;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grid_out", grid_out0, 64'h0);
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_gen_count", 64'(gen_count0), 64'd0);
        reset_n = 1'b1;

        // Blinker, block, corners, glider.
        submit(64'h0000_0008_0808_0000, 8'd1);
        @(negedge clk);
        check("run_busy", 64'(busy0), 64'd1);
        check("run_in_ready", 64'(in_ready0), 64'd0);
        drain();
        check("blinker_const", life_n(64'h0000_0008_0808_0000, 1, 1'b0), 64'h0000_0000_1C00_0000);
        submit(64'h0303, 8'd5);
        submit(64'h8100_0000_0000_0081, 8'd1);
        submit(64'h0000_0000_0007_0402, 8'd32);
        drain();
        for (int i = 0; i < 3; i++) submit({$urandom, $urandom}, 8'($urandom_range(1, 6)));
        drain();

        // Zero generations and the widest count.
        submit(64'hDEAD_BEEF_0123_4567, 8'd0);
        submit(64'h0000_0038_0000_0000, 8'd255);
        drain();

        // Back-pressure: board must hold and new boards must be dropped.
        out_ready = 1'b0;
        hold_exp  = life_n(64'h0000_1818_0660_0000, 2, 1'b0);
        submit(64'h0000_1818_0660_0000, 8'd2);
        k = 0;
        while (!out_valid0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            grid_in  = 64'hFFFF_0000_FFFF_0000;
            num_gens = 8'd3;
            check("hold_grid", grid_out0, hold_exp);
            check("hold_valid", 64'(out_valid0), 64'd1);
            check("hold_in_ready", 64'(in_ready0), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 64'(out_valid0), 64'd0);
        check("release_in_ready", 64'(in_ready0), 64'd1);
        repeat (3) @(negedge clk);
        check("dropped_busy", 64'(busy0), 64'd0);

        // Reset mid-run aborts the job, then a fresh job completes.
        submit(64'h0000_0008_0808_0000, 8'd4);
        repeat (12) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        sb.delete();
        @(negedge clk);
        check("abort_grid_out", grid_out0, 64'h0);
        check("abort_out_valid", 64'(out_valid0), 64'd0);
        check("abort_in_ready", 64'(in_ready0), 64'd1);
        check("abort_gen_count", 64'(gen_count0), 64'd0);
        reset_n = 1'b1;
        submit(64'h0000_0000_0007_0402, 8'd3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
